// File: rtl/lcd_bus_ctrl_if.sv
// Store-side and HD44780-side signals of the LCD bus controller.
interface lcd_bus_ctrl_if;
  logic        lcd_wr_i;
  logic [31:0] lcd_wdata_i;
  logic        lcd_busy_o;
  logic        lcd_ovf_o;
  logic        lcd_on_o;
  logic        lcd_en_o;
  logic        lcd_rs_o;
  logic        lcd_rw_o;
  logic [7:0]  lcd_data_o;

  // Core/store side: drives strobes, observes status and pins.
  modport master (
    output lcd_wr_i, lcd_wdata_i,
    input  lcd_busy_o, lcd_ovf_o, lcd_on_o, lcd_en_o, lcd_rs_o, lcd_rw_o, lcd_data_o
  );

  // Controller side.
  modport slave (
    input  lcd_wr_i, lcd_wdata_i,
    output lcd_busy_o, lcd_ovf_o, lcd_on_o, lcd_en_o, lcd_rs_o, lcd_rw_o, lcd_data_o
  );
endinterface

// File: rtl/lcd_bus_ctrl.sv
// Write-only HD44780 bus controller: turns one-cycle store strobes into timed
// LCD bus cycles (setup, EN pulse, hold, execution wait) with a 1-deep pending
// buffer, a sticky overflow flag and a pollable busy flag. All outputs registered.
module lcd_bus_ctrl #(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_EN    = 12,
  parameter int unsigned T_HOLD  = 2,
  parameter int unsigned T_EXEC  = 2000,
  parameter int unsigned T_CLEAR = 82000,
  parameter int unsigned CNT_W   = 17
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  lcd_bus_ctrl_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StSetup, StEnHi, StHold, StExec} state_e;

  localparam logic [CNT_W-1:0] SetupLast = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] EnLast    = CNT_W'(T_EN - 1);
  localparam logic [CNT_W-1:0] HoldLast  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] ExecLast  = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] ClearLast = CNT_W'(T_CLEAR - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_valid_q, pend_valid_d;
  logic             pend_on_q, pend_on_d;
  logic             pend_rs_q, pend_rs_d;
  logic [7:0]       pend_data_q, pend_data_d;
  logic             on_q, on_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             ovf_q, ovf_d;

  logic             wr_ctrl, wr_norm;
  logic             take_new, take_pend;
  logic             is_clear;
  logic [CNT_W-1:0] exec_last;

  // Bits of the store word that carry no meaning for the LCD.
  logic unused_wdata;
  assign unused_wdata = ^{bus.lcd_wdata_i[29:10], bus.lcd_wdata_i[8]};

  assign wr_ctrl = bus.lcd_wr_i & bus.lcd_wdata_i[30];
  assign wr_norm = bus.lcd_wr_i & ~bus.lcd_wdata_i[30];

  // Clear/home commands need the long execution wait.
  assign is_clear  = ~rs_q & (data_q inside {8'h01, 8'h02, 8'h03});
  assign exec_last = is_clear ? ClearLast : ExecLast;

  // Next-state: bus-cycle sequencing, pending buffer and overflow flag.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    take_new     = 1'b0;
    take_pend    = 1'b0;
    pend_valid_d = pend_valid_q;
    pend_on_d    = pend_on_q;
    pend_rs_d    = pend_rs_q;
    pend_data_d  = pend_data_q;
    on_d         = on_q;
    rs_d         = rs_q;
    data_d       = data_q;
    ovf_d        = ovf_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (wr_norm) begin
          state_d  = StSetup;
          take_new = 1'b1;
        end
      end
      StSetup: begin
        if (cnt_q == SetupLast) begin
          state_d = StEnHi;
          cnt_d   = '0;
        end
      end
      StEnHi: begin
        if (cnt_q == EnLast) begin
          state_d = StHold;
          cnt_d   = '0;
        end
      end
      StHold: begin
        if (cnt_q == HoldLast) begin
          state_d = StExec;
          cnt_d   = '0;
        end
      end
      StExec: begin
        if (cnt_q == exec_last) begin
          cnt_d = '0;
          if (pend_valid_q) begin
            state_d   = StSetup;
            take_pend = 1'b1;
          end else if (wr_norm) begin
            // Back-to-back with no idle cycle; pending stays empty.
            state_d  = StSetup;
            take_new = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    if (take_pend) begin
      on_d         = pend_on_q;
      rs_d         = pend_rs_q;
      data_d       = pend_data_q;
      pend_valid_d = 1'b0;
    end

    if (take_new) begin
      on_d   = bus.lcd_wdata_i[31];
      rs_d   = bus.lcd_wdata_i[9];
      data_d = bus.lcd_wdata_i[7:0];
    end

    // A word not started directly is buffered; the slot frees the same cycle
    // the pending word is handed to SETUP, so that case never drops.
    if (wr_norm && !take_new) begin
      if (!pend_valid_q || take_pend) begin
        pend_valid_d = 1'b1;
        pend_on_d    = bus.lcd_wdata_i[31];
        pend_rs_d    = bus.lcd_wdata_i[9];
        pend_data_d  = bus.lcd_wdata_i[7:0];
      end else begin
        ovf_d = 1'b1;
      end
    end

    // Clear wins over a same-cycle set.
    if (wr_ctrl) begin
      ovf_d = 1'b0;
    end

    en_d   = (state_d == StEnHi);
    busy_d = (state_d != StIdle) | pend_valid_d;
  end

  // State and output registers; reset drops EN and busy immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_on_q    <= 1'b0;
      pend_rs_q    <= 1'b0;
      pend_data_q  <= '0;
      on_q         <= 1'b0;
      rs_q         <= 1'b0;
      data_q       <= '0;
      en_q         <= 1'b0;
      busy_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_on_q    <= pend_on_d;
      pend_rs_q    <= pend_rs_d;
      pend_data_q  <= pend_data_d;
      on_q         <= on_d;
      rs_q         <= rs_d;
      data_q       <= data_d;
      en_q         <= en_d;
      busy_q       <= busy_d;
      ovf_q        <= ovf_d;
    end
  end

  assign bus.lcd_busy_o = busy_q;
  assign bus.lcd_ovf_o  = ovf_q;
  assign bus.lcd_on_o   = on_q;
  assign bus.lcd_en_o   = en_q;
  assign bus.lcd_rs_o   = rs_q;
  assign bus.lcd_rw_o   = 1'b0;
  assign bus.lcd_data_o = data_q;

endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// Self-checking bench for lcd_bus_ctrl with shortened timing parameters.
module tb_lcd_bus_ctrl;

  localparam int unsigned TSetup = 2;
  localparam int unsigned TEn    = 4;
  localparam int unsigned THold  = 2;
  localparam int unsigned TExec  = 10;
  localparam int unsigned TClear = 30;

  logic clk_i;
  logic rst_ni;

  lcd_bus_ctrl_if bus ();

  lcd_bus_ctrl #(
    .T_SETUP (TSetup),
    .T_EN    (TEn),
    .T_HOLD  (THold),
    .T_EXEC  (TExec),
    .T_CLEAR (TClear),
    .CNT_W   (17)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus.slave)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] wdata;
    logic        exp_on;
    logic        exp_rs;
    logic [7:0]  exp_data;
    int          exec;
  } vec_t;

  vec_t vecs [7];

  int n_chk  = 0;
  int n_fail = 0;

  // Cycle bookkeeping updated at every sample point.
  int       cyc       = 0;
  int       en_rises  = 0;
  int       en_hi_cnt = 0;
  int       last_rise = 0;
  int       busy_fall = 0;
  logic [7:0] rise_data = '0;
  logic     en_prev   = 1'b0;
  logic     busy_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc++;
    if (bus.lcd_en_o && !en_prev) begin
      en_rises++;
      last_rise = cyc;
      rise_data = bus.lcd_data_o;
    end
    if (bus.lcd_en_o) en_hi_cnt++;
    if (!bus.lcd_busy_o && busy_prev) busy_fall = cyc;
    en_prev   = bus.lcd_en_o;
    busy_prev = bus.lcd_busy_o;
  endtask

  task automatic write(input logic [31:0] w);
    bus.lcd_wr_i    = 1'b1;
    bus.lcd_wdata_i = w;
    tick();
    bus.lcd_wr_i    = 1'b0;
    bus.lcd_wdata_i = '0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (bus.lcd_busy_o && n < budget) begin
      tick();
      n++;
    end
    check("wait_idle_timeout", {31'd0, bus.lcd_busy_o}, 32'd0);
  endtask

  // One isolated write: checks load at +1, EN placement/width and busy fall.
  task automatic run_vec(input vec_t v, input string tag);
    int c0 = cyc;
    int r0 = en_rises;
    int h0 = en_hi_cnt;
    write(v.wdata);
    check({tag, "_on"},   {31'd0, bus.lcd_on_o},   {31'd0, v.exp_on});
    check({tag, "_rs"},   {31'd0, bus.lcd_rs_o},   {31'd0, v.exp_rs});
    check({tag, "_data"}, {24'd0, bus.lcd_data_o}, {24'd0, v.exp_data});
    check({tag, "_busy"}, {31'd0, bus.lcd_busy_o}, 32'd1);
    wait_idle(200);
    check({tag, "_en_pulses"}, en_rises - r0, 1);
    check({tag, "_en_rise"},   last_rise - c0, 1 + TSetup);
    check({tag, "_en_width"},  en_hi_cnt - h0, TEn);
    check({tag, "_en_data"},   {24'd0, rise_data}, {24'd0, v.exp_data});
    check({tag, "_busy_fall"}, busy_fall - c0, 1 + TSetup + TEn + THold + v.exec);
    check({tag, "_ovf"},       {31'd0, bus.lcd_ovf_o}, 32'd0);
  endtask

  initial begin
    int c0;
    int r0;

    vecs[0] = '{32'h8000_0241, 1'b1, 1'b1, 8'h41, TExec};
    vecs[1] = '{32'h8000_0001, 1'b1, 1'b0, 8'h01, TClear};
    vecs[2] = '{32'h8000_0004, 1'b1, 1'b0, 8'h04, TExec};
    vecs[3] = '{32'h0000_0203, 1'b0, 1'b1, 8'h03, TExec};
    vecs[4] = '{32'h8000_0002, 1'b1, 1'b0, 8'h02, TClear};
    vecs[5] = '{32'h8000_0103, 1'b1, 1'b0, 8'h03, TClear};
    vecs[6] = '{32'h8000_00ff, 1'b1, 1'b0, 8'hff, TExec};

    rst_ni          = 1'b0;
    bus.lcd_wr_i    = 1'b0;
    bus.lcd_wdata_i = '0;
    #22;
    check("rst_busy", {31'd0, bus.lcd_busy_o}, 32'd0);
    check("rst_ovf",  {31'd0, bus.lcd_ovf_o},  32'd0);
    check("rst_on",   {31'd0, bus.lcd_on_o},   32'd0);
    check("rst_en",   {31'd0, bus.lcd_en_o},   32'd0);
    check("rst_rs",   {31'd0, bus.lcd_rs_o},   32'd0);
    check("rst_rw",   {31'd0, bus.lcd_rw_o},   32'd0);
    check("rst_data", {24'd0, bus.lcd_data_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();

    // Isolated writes: normal, clear/home and plain-command variants.
    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      tick();
    end

    // Back-to-back pair: second SETUP follows the first EXEC directly.
    c0 = cyc;
    r0 = en_rises;
    write(32'h8000_0241);
    write(32'h8000_0242);
    wait_idle(200);
    check("b2b_en_pulses", en_rises - r0, 2);
    check("b2b_rise2",     last_rise - c0, 21);
    check("b2b_data2",     {24'd0, rise_data}, 32'h42);
    check("b2b_busy_fall", busy_fall - c0, 37);
    check("b2b_ovf",       {31'd0, bus.lcd_ovf_o}, 32'd0);
    tick();

    // Three writes while busy: third is dropped and flags overflow.
    r0 = en_rises;
    write(32'h8000_0241);
    write(32'h8000_0242);
    write(32'h8000_0243);
    check("drop_ovf_set", {31'd0, bus.lcd_ovf_o}, 32'd1);
    wait_idle(200);
    check("drop_en_pulses", en_rises - r0, 2);
    check("drop_last_data", {24'd0, rise_data}, 32'h42);
    check("drop_ovf_held",  {31'd0, bus.lcd_ovf_o}, 32'd1);
    r0 = en_rises;
    write(32'h4000_0000);
    check("ctrl_ovf_clr", {31'd0, bus.lcd_ovf_o},  32'd0);
    check("ctrl_busy",    {31'd0, bus.lcd_busy_o}, 32'd0);
    repeat (5) tick();
    check("ctrl_no_cycle", en_rises - r0, 0);
    check("ctrl_idle",     {31'd0, bus.lcd_busy_o}, 32'd0);

    // Write on the last EXEC cycle with pending empty.
    c0 = cyc;
    r0 = en_rises;
    write(32'h8000_0241);
    while (cyc < c0 + 1 + TSetup + TEn + THold + TExec - 1) tick();
    write(32'h8000_0250);
    check("lastexec_busy", {31'd0, bus.lcd_busy_o}, 32'd1);
    check("lastexec_data", {24'd0, bus.lcd_data_o}, 32'h50);
    wait_idle(200);
    check("lastexec_en_pulses", en_rises - r0, 2);
    check("lastexec_rise2",     last_rise - c0, 21);
    check("lastexec_busy_fall", busy_fall - c0, 37);
    tick();

    // Asynchronous reset while EN is high.
    c0 = cyc;
    write(32'h8000_0241);
    repeat (3) tick();
    check("mid_en_high", {31'd0, bus.lcd_en_o}, 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_en",   {31'd0, bus.lcd_en_o},   32'd0);
    check("arst_rs",   {31'd0, bus.lcd_rs_o},   32'd0);
    check("arst_data", {24'd0, bus.lcd_data_o}, 32'd0);
    check("arst_busy", {31'd0, bus.lcd_busy_o}, 32'd0);
    @(negedge clk_i);
    rst_ni    = 1'b1;
    en_prev   = 1'b0;
    busy_prev = 1'b0;
    tick();
    run_vec(vecs[0], "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Absolute guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

endmodule
